// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP network and its streaming input loader.
// Holds default frame geometry, the Q7.24 word type and the loader FSM states.
package mlp_pkg;

  localparam int unsigned INPUTS  = 784;
  localparam int unsigned OUTPUTS = 10;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAC_W  = 24;

  typedef logic signed [31:0] q7_24_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/mlp_pixel_convert.sv
// Pixel to Q7.24 word conversion (combinational).
// Build option: MLP_LOADER_NORMALIZE_EN
//   defined   -> word = pix << (FRAC_W - PIX_W), i.e. pix/256 in Q7.24
//   undefined -> word = raw pix in the LSBs, for integer-scaled weights
// Ports:
//   pix   in   PIX_W   unsigned pixel value
//   word  out  DATA_W  zero-extended converted word
module mlp_pixel_convert #(
  parameter int unsigned PIX_W  = mlp_pkg::PIX_W,
  parameter int unsigned DATA_W = mlp_pkg::DATA_W,
  parameter int unsigned FRAC_W = mlp_pkg::FRAC_W
) (
  input  logic        [PIX_W-1:0]  pix,
  output logic signed [DATA_W-1:0] word
);

  // The pixel must fit inside the fraction, and the fraction inside the word.
  if ((FRAC_W < PIX_W) || (DATA_W <= FRAC_W)) begin : g_bad_fmt
    $error("mlp_pixel_convert: unsupported PIX_W/FRAC_W/DATA_W combination");
  end

`ifdef MLP_LOADER_NORMALIZE_EN
  localparam int unsigned SHIFT = FRAC_W - PIX_W;

  always_comb begin
    word = DATA_W'(pix) << SHIFT;
  end
`else
  always_comb begin
    word = DATA_W'(pix);
  end
`endif

endmodule

// File: rtl/mlp_input_loader.sv
// Streaming front end for mlp_neural_net: one pixel per valid/ready beat is
// converted and written into a frame array that is presented in parallel on
// data_inputs. A complete frame is frozen until frame_ack; intake stalls
// meanwhile. Frame length mismatches raise a one-cycle len_err pulse.
// Build option: MLP_LOADER_NORMALIZE_EN (see mlp_pixel_convert).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pix_valid     in   pixel beat offered
//   pix_ready     out  loader accepts beat (LOAD state)
//   pix_data      in   PIX_W pixel value
//   pix_last      in   final pixel of frame
//   data_inputs   out  [0:INPUTS-1] x DATA_W assembled frame
//   frame_valid   out  frame complete and stable (FULL state)
//   frame_ack     in   consumer has sampled the frame
//   len_err       out  one-cycle pulse on frame length mismatch
module mlp_input_loader #(
  parameter int unsigned INPUTS = mlp_pkg::INPUTS,
  parameter int unsigned PIX_W  = mlp_pkg::PIX_W,
  parameter int unsigned DATA_W = mlp_pkg::DATA_W,
  parameter int unsigned FRAC_W = mlp_pkg::FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic        [PIX_W-1:0]  pix_data,
  input  logic                     pix_last,
  output logic signed [DATA_W-1:0] data_inputs [0:INPUTS-1],
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     len_err
);

  import mlp_pkg::*;

  localparam int unsigned      IDX_W    = $clog2(INPUTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUTS - 1);

  loader_state_t             state;
  loader_state_t             state_nxt;
  logic        [IDX_W-1:0]   idx;
  logic                      accept;
  logic                      at_end;
  logic                      ready_nxt;
  logic                      valid_nxt;
  logic                      err_nxt;
  logic signed [DATA_W-1:0]  word;

  mlp_pixel_convert #(
    .PIX_W  (PIX_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_convert (
    .pix  (pix_data),
    .word (word)
  );

  // pix_ready is only high in LOAD, so accept implies LOAD.
  assign accept = pix_valid && pix_ready;
  assign at_end = (idx == IDX_LAST);

  // State register plus registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      pix_ready   <= 1'b0;
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix_ready   <= ready_nxt;
      frame_valid <= valid_nxt;
      len_err     <= err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (accept && at_end) state_nxt = FULL;
      FULL: if (frame_ack)        state_nxt = LOAD;
      default:                    state_nxt = LOAD;
    endcase
  end

  // Output logic: status registers follow the state being entered, so they
  // line up with the state register one cycle later.
  always_comb begin
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    ready_nxt = (state_nxt == LOAD);
    valid_nxt = (state_nxt == FULL);
    // Mismatch: last slot without pix_last, or pix_last before the last slot.
    err_nxt   = accept && (at_end != pix_last);
  end

  // Index counter and frame array write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      for (int i = 0; i < int'(INPUTS); i++) begin
        data_inputs[i] <= '0;
      end
    end else if (accept) begin
      data_inputs[idx] <= word;
      if (at_end || pix_last) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mlp_input_loader.sv
// Self-checking bench for mlp_input_loader: the driver issues pixel beats and
// pushes expected frames / frame_valid rise cycles / len_err cycles into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mlp_input_loader;

  localparam int N = 784;

`ifdef MLP_LOADER_NORMALIZE_EN
  localparam logic [31:0] W5   = 32'h0005_0000;
  localparam logic [31:0] W783 = 32'h000F_0000;
  localparam logic [31:0] WFF  = 32'h00FF_0000;
`else
  localparam logic [31:0] W5   = 32'h0000_0005;
  localparam logic [31:0] W783 = 32'h0000_000F;
  localparam logic [31:0] WFF  = 32'h0000_00FF;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pix_valid = 1'b0;
  logic              pix_last = 1'b0;
  logic              frame_ack = 1'b0;
  logic [7:0]        pix_data = 8'h00;
  logic              pix_ready;
  logic              frame_valid;
  logic              len_err;
  logic signed [31:0] data_inputs [0:N-1];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [31:0] exp_words [$];
  int          exp_rise  [$];
  int          exp_err   [$];
  logic [31:0] model [0:N-1];
  logic [31:0] cur   [0:N-1];
  int          m_idx = 0;
  logic        prev_valid = 1'b0;

  mlp_input_loader dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .data_inputs (data_inputs),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input int exp_cyc);
    vectors++;
    errors++;
    $display("FAIL %s: event expected at cycle %0d not seen (now %0d)", name, exp_cyc, cyc);
  endtask

  function automatic logic [31:0] conv(input logic [7:0] p);
`ifdef MLP_LOADER_NORMALIZE_EN
    return {8'h00, p, 16'h0000};
`else
    return {24'h000000, p};
`endif
  endfunction

  function automatic logic [7:0] pixel(input int k, input bit pat);
    logic [7:0] v;
    v = 8'(k);
    return pat ? (v ^ 8'hFF) : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = '0;
    m_idx = 0;
  endtask

  // Reference behaviour of one accepted beat; events land the cycle after the edge.
  task automatic model_accept(input logic [7:0] p, input bit last);
    model[m_idx] = conv(p);
    if (m_idx == N - 1) begin
      for (int i = 0; i < N; i++) exp_words.push_back(model[i]);
      exp_rise.push_back(cyc + 1);
      if (!last) exp_err.push_back(cyc + 1);
      m_idx = 0;
    end else if (last) begin
      exp_err.push_back(cyc + 1);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic send_frame(input int n, input int last_at, input bit pat, input bit gaps);
    for (int k = 0; k < n; k++) begin
      bit done;
      int tries;
      logic [7:0] p;
      done  = 1'b0;
      tries = 0;
      p     = pixel(k, pat);
      while (!done) begin
        @(negedge clk);
        pix_data  = p;
        pix_last  = (k == last_at);
        pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pix_valid && pix_ready) begin
          model_accept(p, k == last_at);
          done = 1'b1;
        end else if (++tries > 50) begin
          miss("beat_accept", cyc);
          done = 1'b1;
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!frame_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("frame_valid_wait", 32'(frame_valid), 32'd1);
  endtask

  task automatic hold_and_ack(input int hold);
    repeat (hold) @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("fv_after_ack", 32'(frame_valid), 32'd0);
    chk("ready_after_ack", 32'(pix_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    for (int i = 0; i < N; i++) chk($sformatf("rst_word[%0d]", i), data_inputs[i], 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(pix_ready), 32'd1);
    chk("fv_after_rst", 32'(frame_valid), 32'd0);
  endtask

  // Monitor: compares frame presentation, hold stability, ready during FULL and len_err.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      while (exp_err.size() > 0 && exp_err[0] < cyc) miss("len_err", exp_err.pop_front());
      while (exp_rise.size() > 0 && exp_rise[0] < cyc) miss("frame_valid_rise", exp_rise.pop_front());
      if (len_err) begin
        if (exp_err.size() == 0) begin
          chk("unexpected_len_err", 32'(len_err), 32'd0);
        end else begin
          chk("len_err_cycle", 32'(cyc), 32'(exp_err.pop_front()));
        end
      end
      if (frame_valid && !prev_valid) begin
        if (exp_rise.size() == 0 || exp_words.size() < N) begin
          chk("unexpected_frame_valid", 32'(frame_valid), 32'd0);
        end else begin
          chk("frame_valid_cycle", 32'(cyc), 32'(exp_rise.pop_front()));
          for (int i = 0; i < N; i++) begin
            cur[i] = exp_words.pop_front();
            chk($sformatf("word[%0d]", i), data_inputs[i], cur[i]);
          end
        end
      end
      if (frame_valid) chk("ready_in_full", 32'(pix_ready), 32'd0);
      if (!frame_valid && prev_valid) begin
        for (int i = 0; i < N; i++) chk($sformatf("hold_word[%0d]", i), data_inputs[i], cur[i]);
      end
      prev_valid <= frame_valid;
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("init_pix_ready", 32'(pix_ready), 32'd0);
    chk("init_frame_valid", 32'(frame_valid), 32'd0);
    chk("init_word0", data_inputs[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_ready_release", 32'(pix_ready), 32'd1);

    // frame_ack while loading has no effect
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_in_load_ready", 32'(pix_ready), 32'd1);
    chk("ack_in_load_fv", 32'(frame_valid), 32'd0);

    // reset after 100 beats of a frame
    send_frame(100, -1, 1'b0, 1'b0);
    do_reset();

    // clean frame, pixel k = k mod 256
    send_frame(N, N - 1, 1'b0, 1'b0);
    wait_valid();
    chk("dir_word5", data_inputs[5], W5);
    chk("dir_word783", data_inputs[783], W783);
    hold_and_ack(20);

    // same frame with random idle cycles
    send_frame(N, N - 1, 1'b0, 1'b1);
    wait_valid();
    hold_and_ack(20);

    // early last on beat 10, then a full inverted frame
    send_frame(10, 9, 1'b0, 1'b0);
    send_frame(N, N - 1, 1'b1, 1'b0);
    wait_valid();
    chk("dir_word0_ff", data_inputs[0], WFF);
    chk("dir_word1_fe", data_inputs[1], conv(8'hFE));
    hold_and_ack(3);

    // full frame with no pix_last: frame delivered and len_err together
    send_frame(N, -1, 1'b0, 1'b0);
    wait_valid();
    hold_and_ack(1);

    repeat (5) @(negedge clk);
    chk("pending_len_err", 32'(exp_err.size()), 32'd0);
    chk("pending_frames", 32'(exp_rise.size()), 32'd0);
    chk("pending_words", 32'(exp_words.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
